// File: rtl/bcd_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_ctrl_pkg
// Description : FSM state encoding, BCD digit limits and the prescaler width
//               helper for the BCD counter controller.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    // A prescale of 1 still needs a one-bit register that simply stays at 0.
    function automatic int pre_width(input int prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_cell.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_cell
// Description : One BCD digit with carry/borrow out. BCD_DOWN_EN adds the dn
//               input selecting decrement and an all-9s load on clr.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_cell
    import bcd_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       cin,
`ifdef BCD_DOWN_EN
    input  logic       dn,
`endif
    output logic [3:0] q,
    output logic       cout
);

    logic [3:0] r_q;
    logic       w_dn;
    logic       w_at_end;

`ifdef BCD_DOWN_EN
    assign w_dn = dn;
`else
    assign w_dn = 1'b0;
`endif

    assign w_at_end = w_dn ? (r_q == BCD_MIN) : (r_q == BCD_MAX);
    assign cout     = cin && w_at_end;
    assign q        = r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= BCD_MIN;
        end else if (clr) begin
            r_q <= w_dn ? BCD_MAX : BCD_MIN;
        end else if (cin) begin
            if (w_at_end) begin
                r_q <= w_dn ? BCD_MAX : BCD_MIN;
            end else begin
                r_q <= w_dn ? (r_q - 4'd1) : (r_q + 4'd1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bcd_count_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bcd_count_ctrl
// Description : Start/stop/clear sequencer for a DIGITS-long BCD counter with
//               prescaler and target compare. BCD_DOWN_EN adds up_dn.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_count_ctrl
    import bcd_ctrl_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
`ifdef BCD_DOWN_EN
    input  logic                  up_dn,
`endif
    input  logic [4*DIGITS-1:0]   target,
    output logic [4*DIGITS-1:0]   q,
    output logic                  tick,
    output logic                  wrap,
    output logic                  busy,
    output logic                  done
);

    localparam int           PW         = pre_width(PRESCALE);
    localparam logic [PW-1:0] C_PRE_LAST = PW'(PRESCALE - 1);

    state_t                r_state;
    logic [PW-1:0]         r_pre;
    logic                  r_tick;
    logic                  r_wrap;
    logic                  r_busy;
    logic                  r_done;

    logic [4*DIGITS-1:0]   w_q;
    logic [DIGITS:0]       w_carry;
    logic                  w_start_ok;
    logic                  w_clr;
    logic                  w_match;
    logic                  w_tick;
`ifdef BCD_DOWN_EN
    logic                  w_dn;

    // Clear always zeroes; a start load or a tick follows the direction input.
    assign w_dn = !clear && !up_dn;
`endif

    // stop outranks start, so a simultaneous start is dropped.
    assign w_start_ok = start && !stop && !clear;
    assign w_clr      = clear || (w_start_ok && (r_state == ST_IDLE || r_state == ST_DONE));
    assign w_match    = (w_q == target);
    assign w_tick     = (r_state == ST_RUN) && !clear && !stop && !w_match && (r_pre == C_PRE_LAST);
    assign w_carry[0] = w_tick;

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            bcd_digit_cell u_cell (
                .clk  (clk),
                .rst  (rst),
                .clr  (w_clr),
                .cin  (w_carry[i]),
`ifdef BCD_DOWN_EN
                .dn   (w_dn),
`endif
                .q    (w_q[4*i +: 4]),
                .cout (w_carry[i+1])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_pre   <= '0;
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_tick <= w_tick;
            r_wrap <= w_carry[DIGITS];
            r_done <= 1'b0;
            if (clear) begin
                r_state <= ST_IDLE;
                r_pre   <= '0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE: begin
                        if (w_start_ok) begin
                            r_state <= ST_RUN;
                            r_pre   <= '0;
                            r_busy  <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (stop) begin
                            r_state <= ST_PAUSE;
                        end else if (w_match) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else if (r_pre == C_PRE_LAST) begin
                            r_pre <= '0;
                        end else begin
                            r_pre <= r_pre + PW'(1);
                        end
                    end
                    ST_PAUSE: begin
                        if (w_start_ok) begin
                            r_state <= ST_RUN;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign q    = w_q;
    assign tick = r_tick;
    assign wrap = r_wrap;
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_bcd_count_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_count_ctrl
// Description : Directed and random stimulus for bcd_count_ctrl, checked every
//               cycle against an integer-count reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_count_ctrl;

    localparam int DIGITS   = 4;
    localparam int PRESCALE = 4;
    localparam int MODV     = 10 ** DIGITS;

    logic                clk    = 1'b0;
    logic                rst    = 1'b1;
    logic                start  = 1'b0;
    logic                stop   = 1'b0;
    logic                clear  = 1'b0;
    logic [4*DIGITS-1:0] target = '0;
    logic [4*DIGITS-1:0] q;
    logic                tick, wrap, busy, done;
`ifdef BCD_DOWN_EN
    logic                up_dn  = 1'b1;
`endif

    int n_checks = 0;
    int n_errs   = 0;

    typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mstate_e;
    mstate_e m_st;
    int      m_cnt;
    int      m_pre;
    bit      m_tick, m_wrap, m_done;

    bcd_count_ctrl #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .stop   (stop),
        .clear  (clear),
`ifdef BCD_DOWN_EN
        .up_dn  (up_dn),
`endif
        .target (target),
        .q      (q),
        .tick   (tick),
        .wrap   (wrap),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        logic [4*DIGITS-1:0] r = '0;
        int t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s actual=%h expected=%h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = M_IDLE; m_cnt = 0; m_pre = 0;
        m_tick = 0; m_wrap = 0; m_done = 0;
    endtask

    // Reference behaviour on one rising edge, using the inputs seen at that edge.
    task automatic model_edge();
        bit dir_up;
`ifdef BCD_DOWN_EN
        dir_up = up_dn;
`else
        dir_up = 1'b1;
`endif
        m_tick = 0; m_wrap = 0; m_done = 0;
        if (clear) begin
            m_st = M_IDLE; m_cnt = 0; m_pre = 0;
        end else if ((m_st == M_IDLE || m_st == M_DONE) && start && !stop) begin
            m_st = M_RUN; m_pre = 0;
            m_cnt = dir_up ? 0 : MODV - 1;
        end else if (m_st == M_RUN) begin
            if (stop) begin
                m_st = M_PAUSE;
            end else if (to_bcd(m_cnt) == target) begin
                m_st = M_DONE; m_done = 1;
            end else if (m_pre == PRESCALE - 1) begin
                m_tick = 1; m_pre = 0;
                if (dir_up) begin
                    m_wrap = (m_cnt == MODV - 1);
                    m_cnt  = (m_cnt + 1) % MODV;
                end else begin
                    m_wrap = (m_cnt == 0);
                    m_cnt  = (m_cnt + MODV - 1) % MODV;
                end
            end else begin
                m_pre++;
            end
        end else if (m_st == M_PAUSE && start && !stop) begin
            m_st = M_RUN;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("q",    32'(q),    32'(to_bcd(m_cnt)));
        check_eq("tick", 32'(tick), 32'(m_tick));
        check_eq("wrap", 32'(wrap), 32'(m_wrap));
        check_eq("busy", 32'(busy), 32'(m_st == M_RUN || m_st == M_PAUSE));
        check_eq("done", 32'(done), 32'(m_done));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic clear_step();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    // Steps until tick is seen; returns the step number (0 if not seen in the bound).
    task automatic steps_to_tick(input int bound, output int lat);
        lat = 0;
        for (int i = 1; i <= bound && lat == 0; i++) begin
            step();
            if (tick) lat = i;
        end
    endtask

    initial begin
        int lat, nd, nt, nw;
        bit hit;

        model_reset();
        repeat (10) @(posedge clk);
        #1;
        check_eq("rst_q",    32'(q),    32'h0);
        check_eq("rst_tick", 32'(tick), 32'h0);
        check_eq("rst_wrap", 32'(wrap), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_done", 32'(done), 32'h0);
        rst = 1'b0;

        // Count to 0012 and finish
        target = 16'h0012;
        pulse_start();
        steps_to_tick(20, lat);
        check_eq("first_tick_lat", 32'(lat), 32'(PRESCALE));
        nd = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (done) nd++;
        end
        check_eq("done_count", 32'(nd), 32'd1);
        check_eq("done_q", 32'(q), 32'h0012);
        check_eq("done_busy", 32'(busy), 32'h0);

        // Pause at 0005, then resume
        target = 16'h00A0;
        pulse_start();
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            step();
            hit = (q == 16'h0005);
        end
        check_eq("reach_5", 32'(hit), 32'h1);
        stop = 1'b1;
        nt = 0;
        repeat (20) begin
            step();
            if (tick) nt++;
        end
        stop = 1'b0;
        check_eq("pause_q", 32'(q), 32'h0005);
        check_eq("pause_ticks", 32'(nt), 32'h0);
        check_eq("pause_busy", 32'(busy), 32'h1);
        pulse_start();
        steps_to_tick(20, lat);
        check_eq("resume_lat", 32'(lat), 32'(PRESCALE));
        check_eq("resume_q", 32'(q), 32'h0006);

        // All commands together: clear wins
        start = 1'b1; stop = 1'b1; clear = 1'b1;
        step();
        start = 1'b0; stop = 1'b0; clear = 1'b0;
        check_eq("prio_q", 32'(q), 32'h0);
        check_eq("prio_busy", 32'(busy), 32'h0);

        // target zero finishes without counting
        target = 16'h0000;
        pulse_start();
        step();
        check_eq("t0_done", 32'(done), 32'h1);
        check_eq("t0_tick", 32'(tick), 32'h0);
        repeat (4) step();
        clear_step();

        // Asynchronous reset mid-count
        target = 16'h00A0;
        pulse_start();
        hit = 0;
        for (int i = 0; i < 400 && !hit; i++) begin
            step();
            hit = (q == 16'h0037);
        end
        check_eq("reach_37", 32'(hit), 32'h1);
        #3;
        rst = 1'b1;
        #1;
        check_eq("arst_q", 32'(q), 32'h0);
        check_eq("arst_busy", 32'(busy), 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Full wrap 9999 -> 0000 with a non-BCD target
        target = 16'h00A0;
        pulse_start();
        nw = 0;
        for (int i = 0; i < 4 * MODV + 20; i++) begin
            step();
            if (wrap) begin
                nw++;
                check_eq("wrap_q", 32'(q), 32'h0);
            end
        end
        check_eq("wrap_count", 32'(nw), 32'd1);
        check_eq("wrap_busy", 32'(busy), 32'h1);
        clear_step();

`ifdef BCD_DOWN_EN
        // Down count 9999 -> 9995
        up_dn  = 1'b0;
        target = 16'h9995;
        pulse_start();
        check_eq("dn_load", 32'(q), 32'h9999);
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done) nd++;
        end
        check_eq("dn_done", 32'(nd), 32'd1);
        check_eq("dn_q", 32'(q), 32'h9995);
        clear_step();
        // Start up from 0000, switch to down before the first tick
        up_dn  = 1'b1;
        target = 16'h00A0;
        pulse_start();
        up_dn  = 1'b0;
        nw = 0;
        for (int i = 0; i < PRESCALE + 2; i++) begin
            step();
            if (wrap) nw++;
        end
        check_eq("dn_wrap", 32'(nw), 32'd1);
        check_eq("dn_wrap_q", 32'(q), 32'h9999);
        up_dn = 1'b1;
        clear_step();
`endif

        // Random commands and targets
        for (int i = 0; i < 3000; i++) begin
            clear = ($urandom_range(0, 99) < 2);
            stop  = ($urandom_range(0, 99) < 5);
            start = ($urandom_range(0, 99) < 10);
            if ($urandom_range(0, 99) < 3) begin
                if ($urandom_range(0, 3) == 0)
                    target = 16'(16'h00A0 | 16'($urandom_range(0, 15) << 8));
                else
                    target = to_bcd($urandom_range(0, 40));
            end
`ifdef BCD_DOWN_EN
            if ($urandom_range(0, 99) < 3) up_dn = ~up_dn;
`endif
            step();
        end
        clear = 1'b0; stop = 1'b0; start = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bcd_count_ctrl.md
Name: bcd_count_ctrl

Overview:
Sequencing controller for a cascade of BCD digit counters. It runs a prescaler that generates count-enable ticks, ripples carries through DIGITS internal BCD digit cells, and compares the count against a programmable BCD target. A start/stop/clear command interface drives a 4-state FSM and flags completion. It sits between front-panel/host control logic and the BCD display/timer datapath.

Parameters:
DIGITS, 4, number of cascaded BCD digits (1..8)
PRESCALE, 50, clk cycles per count step (>=1); PRESCALE=1 means a tick every cycle in RUN

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  level-sampled command: begin/resume counting
stop  input  1  level-sampled command: pause counting
clear  input  1  level-sampled command: zero count, return to IDLE
target  input  4*DIGITS  BCD terminal value, digit 0 in [3:0]
q  output  4*DIGITS  current BCD count, registered
tick  output  1  one-cycle pulse, the prescaler enable that advanced q
wrap  output  1  one-cycle pulse coincident with the all-9s -> all-0s transition
busy  output  1  high in RUN or PAUSE
done  output  1  one-cycle pulse on entry to DONE

Behaviour:
- Reset (rst=1, async): state=IDLE, q=0, prescaler=0, tick=0, wrap=0, busy=0, done=0.
- FSM states: IDLE, RUN, PAUSE, DONE. Command priority: clear > stop > start.
- clear (any state): next edge q=0, prescaler=0, state=IDLE.
- start in IDLE or DONE: next edge q=0, prescaler=0, state=RUN. start in PAUSE: state=RUN, q and prescaler kept. start in RUN: ignored.
- stop in RUN: state=PAUSE, prescaler frozen. stop elsewhere: ignored.
- Prescaler: counts 0..PRESCALE-1 only in RUN. Terminal value asserts tick for that cycle and reloads 0.
- Digit chain: cin0=tick. cin(i+1)=cin(i) AND q(i)==9. A digit with cin increments, and 9 wraps to 0. The carry ripples combinationally, so all digits update on the same edge.
- wrap=tick AND all digits ==9. Registered with q, so it is visible in the cycle after the edge.
- Terminal: in RUN, when registered q==target, the next edge moves to DONE. done=1 for that one cycle. No further ticks are issued.
- Latency: the first increment occurs PRESCALE cycles after the edge that samples start from IDLE.
- target==0: start from IDLE gives q=0==target, so DONE is reached one cycle after RUN entry without counting.
- target containing a non-BCD nibble (>9): never matches. The counter wraps indefinitely until stop or clear.
- target changes during RUN take effect on the next comparison cycle.
- The target is reached only in RUN. A match in PAUSE does not enter DONE until resumed.
- DONE holds q until start or clear.
- rst asserted mid-count aborts immediately to reset values.

Optional Feature:
Macro BCD_DOWN_EN.
- Defined: adds input up_dn (1=up, 0=down).
- In down mode, a digit with cin decrements and 0 wraps to 9. Borrow is cin(i+1)=cin(i) AND q(i)==0.
- wrap fires on all-0s -> all-9s.
- start from IDLE/DONE in down mode loads q=all 9s instead of 0.
- up_dn is sampled per tick.
- Undefined: no up_dn port, up-count only. Logic is identical to the up path above.

Decomposition:
- Package bcd_ctrl_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2, ST_DONE=2'd3
  - BCD_MAX=4'd9, BCD_MIN=4'd0
  - the prescaler width function (clog2 of PRESCALE)
- One sub-module, bcd_digit_cell: a single 4-bit BCD digit.
  - Inputs: clk, rst, clr, cin, optional dn.
  - Outputs: q[3:0], cout.
  - Instantiated DIGITS times with a generate loop.
- The FSM, prescaler and comparator stay in bcd_count_ctrl.

Test Plan:
- DIGITS=4, PRESCALE=4. Hold rst=1 for 10 cycles, then release; start pulse 1 cycle, target=16'h0012 -> first tick 4 cycles after start, q steps 0000..0012, done pulses once, q holds 0012, busy=0.
- target=16'h9999, preset run to 9999 via long run -> q reaches 9999, then DONE. Repeat with target=16'h00A0 -> q 9999->0000 with wrap=1 for exactly one cycle, counting continues.
- In RUN at q=0005, stop for 20 cycles -> q stays 0005, tick=0, busy=1. Then start -> the next tick arrives after the remaining prescale count and q=0006.
- Assert start, stop and clear in the same cycle during RUN -> clear wins: q=0000, state IDLE, busy=0.
- target=16'h0000, start -> done pulses 2 cycles after start with no tick. Assert rst mid-count at q=0037 -> q=0000 asynchronously, before the next clk edge.
- BCD_DOWN_EN, up_dn=0, target=16'h9995, start -> q=9999, 9998 ... 9995, then done. Separately, run from 0000 in down mode -> q becomes 9999 with wrap=1.
